seq_signed_mult_param: RTL and testbench
========================================

Name: seq_signed_mult_param

Overview:
Parametrised, self-sequenced successor to the 8-bit signed shift-add multiplier. It replaces the external load/shift_en/reg_en/psel sequencing with an internal FSM and a start/busy/done handshake. It also adds a signed/unsigned mode, a full 2*WIDTH product and early termination on the leading zeros of the multiplier. It sits in the datapath as a multi-cycle arithmetic unit.

Parameters:
WIDTH, 8, operand width in bits (WIDTH >= 2); product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH+1), width of the internal bit counter. Derived; not overridden.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  reset, asynchronous, active-low.
start  input  1  request; sampled only in IDLE.
signed_mode  input  1  1 = operands are two's complement; 0 = operands are unsigned. Sampled with start.
multiplicand  input  WIDTH  operand A, sampled with start.
multiplier  input  WIDTH  operand B, sampled with start.
busy  output  1  high in RUN and FIX.
done  output  1  one-cycle pulse when product is updated.
product  output  2*WIDTH  result: two's complement if signed, else unsigned. Held until the next done.
sign  output  1  1 iff the registered product is negative (signed mode only).
zflag  output  1  1 iff the registered product == 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done, sign, zflag = 0.
  - product = 0.
  - All internal registers = 0.
- Deassertion is synchronous to clk.
- Reset mid-operation aborts with no done pulse; the old product is lost (cleared to 0).
- States: IDLE, RUN, FIX.
- IDLE, start=1 at an edge:
  - Latch magA=|A| and magB=|B| (WIDTH-bit unsigned). In signed mode, magnitude of -2^(WIDTH-1) is 2^(WIDTH-1).
  - Latch neg = signed_mode & (A[MSB] ^ B[MSB]).
  - Clear acc (2*WIDTH bits) and the counter.
  - If magA==0 or magB==0, go to FIX; otherwise go to RUN.
- RUN, one multiplier bit per cycle:
  - If magB[0], acc += magA << cnt.
  - magB >>= 1; cnt++.
  - Go to FIX when the shifted magB becomes 0 or cnt reaches WIDTH. This is early termination.
- FIX, one cycle:
  - product <= neg ? -acc : acc.
  - sign <= neg & (acc != 0).
  - zflag <= (acc == 0).
  - done <= 1 for exactly this cycle.
  - Go to IDLE.
- Latency: let n = bit-length of |B|, or n = 0 if either operand is zero. done is high n+1 cycles after the edge that sampled start. Maximum latency is WIDTH+1.
- start while busy is ignored; no queueing. Operand changes while busy have no effect.
- Back-to-back: start may be asserted in the same cycle done is high. The FSM is already in IDLE then, so it is accepted.
- Arithmetic rules:
  - acc never overflows: signed extreme (-2^(W-1))^2 = 2^(2W-2); unsigned max (2^W-1)^2 < 2^(2W).
  - Negation is modulo 2^(2W).
- product, sign and zflag change only in FIX or on reset.

Test Plan:
1. WIDTH=8, signed, A=5, B=-5 (0xFB), start 1 cycle -> |B|=5 so n=3; done 4 cycles after start; product=0xFFE7 (-25), sign=1, zflag=0; busy high for 4 cycles.
2. Signed, A=0x80, B=0x80 (-128*-128) -> n=8; done after 9 cycles; product=0x4000, sign=0.
3. Unsigned, A=0xFF, B=0xFF -> done after 9 cycles; product=0xFE01, sign=0. Repeat in signed mode -> product=0x0001.
4. Signed, A=0, B=-7 -> done 1 cycle after start; product=0, zflag=1, sign=0 (no negative zero). Repeat with A=-7, B=0 -> same response.
5. Start A=3, B=3. Pulse start with A=9, B=9 while busy, then pulse start with A=2, B=-2 in the done cycle:
   - First done gives product=9.
   - Second op is accepted and returns 0xFFFC.
6. Signed A=100, B=100, drop rst_n during cycle 3 of RUN -> all outputs 0 immediately, no done. After release, A=-1, B=1 -> product=0xFFFF, done after 2 cycles.

Source files
------------

// File: rtl/seq_signed_mult_param.sv
// Self-sequenced shift-add multiplier: signed/unsigned operands, full 2*WIDTH product,
// early exit once the remaining multiplier magnitude bits are all zero.
module seq_signed_mult_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 sign,
  output logic                 zflag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_mag_a;
  logic [WIDTH-1:0]     r_mag_b;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_sign;
  logic                 r_zflag;
  logic                 r_done;

  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic                 w_neg;
  logic [WIDTH-1:0]     w_mag_b_shr;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic [2*WIDTH-1:0]   w_addend;

  // Unsigned WIDTH-bit negation maps -2^(WIDTH-1) onto its true magnitude 2^(WIDTH-1).
  assign w_mag_a     = (signed_mode && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
  assign w_mag_b     = (signed_mode && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
  assign w_neg       = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
  assign w_mag_b_shr = r_mag_b >> 1;
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_addend    = {{WIDTH{1'b0}}, r_mag_a} << r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          if ((w_mag_a == '0) || (w_mag_b == '0)) begin
            w_state_nxt = FIX;
          end else begin
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if ((w_mag_b_shr == '0) || (w_cnt_inc == CNT_W'(WIDTH))) begin
          w_state_nxt = FIX;
        end
      end
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag_a   <= '0;
      r_mag_b   <= '0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_sign    <= 1'b0;
      r_zflag   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mag_a <= w_mag_a;
            r_mag_b <= w_mag_b;
            r_neg   <= w_neg;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          if (r_mag_b[0]) begin
            r_acc <= r_acc + w_addend;
          end
          r_mag_b <= w_mag_b_shr;
          r_cnt   <= w_cnt_inc;
        end
        FIX: begin
          r_product <= r_neg ? -r_acc : r_acc;
          r_sign    <= r_neg & (r_acc != '0);
          r_zflag   <= (r_acc == '0);
          r_done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state == RUN) || (r_state == FIX);
  assign done    = r_done;
  assign product = r_product;
  assign sign    = r_sign;
  assign zflag   = r_zflag;

endmodule

// File: tb/tb_seq_signed_mult_param.sv
// Directed bench for seq_signed_mult_param (WIDTH=8) with hand-computed products and latencies.
module tb_seq_signed_mult_param;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_mode;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        sign;
  logic        zflag;

  int n_chk = 0;
  int n_err = 0;

  seq_signed_mult_param #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .sign         (sign),
    .zflag        (zflag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after the start-sampling edge; lat counts edges until done is seen.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic sm, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] ep, input logic es, input logic ez, input int elat);
    int lat, bcnt;
    @(negedge clk);
    start = 1'b1; signed_mode = sm; multiplicand = a; multiplier = b;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bcnt);
    check({tag, "_lat"},   lat,     elat);
    check({tag, "_busy"},  bcnt,    elat);
    check({tag, "_prod"},  product, {16'h0, ep});
    check({tag, "_sign"},  sign,    es);
    check({tag, "_zflag"}, zflag,   ez);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, done, 1'b0);
  endtask

  initial begin
    int lat, bcnt;
    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; multiplicand = '0; multiplier = '0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_prod", product, 16'h0);
    check("rst_flags", {sign, zflag}, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run_op("s5xm5",    1'b1, 8'h05, 8'hFB, 16'hFFE7, 1'b1, 1'b0, 4);
    run_op("s80x80",   1'b1, 8'h80, 8'h80, 16'h4000, 1'b0, 1'b0, 9);
    run_op("uffxff",   1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 9);
    run_op("sffxff",   1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b0, 1'b0, 2);
    run_op("s0xm7",    1'b1, 8'h00, 8'hF9, 16'h0000, 1'b0, 1'b1, 1);
    run_op("sm7x0",    1'b1, 8'hF9, 8'h00, 16'h0000, 1'b0, 1'b1, 1);
    run_op("u80x02",   1'b0, 8'h80, 8'h02, 16'h0100, 1'b0, 1'b0, 3);

    // Start while busy is dropped; start in the done cycle is accepted.
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b1; multiplicand = 8'd3; multiplier = 8'd3;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    start = 1'b1; multiplicand = 8'd9; multiplier = 8'd9;
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b_busy_ign", busy, 1'b1);
    wait_done(lat, bcnt);
    check("b2b_lat1", lat, 2);
    check("b2b_prod1", product, 16'd9);
    start = 1'b1; multiplicand = 8'd2; multiplier = 8'hFE;
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b_accept", busy, 1'b1);
    wait_done(lat, bcnt);
    check("b2b_lat2", lat, 3);
    check("b2b_prod2", product, 16'hFFFC);
    check("b2b_sign2", sign, 1'b1);

    // Reset in the third RUN cycle aborts and clears everything.
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b1; multiplicand = 8'd100; multiplier = 8'd100;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_prod", product, 16'h0);
    check("abort_flags", {sign, zflag}, 2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1 check("abort_nodone", done, 1'b0);
    end
    run_op("post_rst", 1'b1, 8'hFF, 8'h01, 16'hFFFF, 1'b1, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
